simd_array: RTL and testbench
=============================

# simd_array

Lane-parallel integer arithmetic array: WIDTH identical lanes each apply the same operation (ADD, SUB, MAC, MUL) to their own UNIT_SIZE-bit operand pair. The block is the execution datapath of the SIMD multiprocessor. A controller broadcasts one opcode and a run strobe, and the block returns a registered, packed result vector one cycle later. In MAC mode each lane keeps a running accumulator.

## Interface
- UNIT_SIZE, 32: lane data width in bits (≥ 2).
- WIDTH, 5: number of lanes (≥ 1).

- i_clk  in  1: sole clock, rising edge.
- i_rstn  in  1: reset, asynchronous, active-low.
- i_op  in  2: operation; 0 = ADD, 1 = SUB, 2 = MAC, 3 = MUL.
- i_a  in  [WIDTH] x UNIT_SIZE (unpacked array): operand A per lane, index 0..WIDTH-1.
- i_b  in  [WIDTH] x UNIT_SIZE (unpacked array): operand B per lane.
- i_run  in  1: execute strobe, sampled each rising edge.
- o_valid  out  1: result-updated flag.
- o_res  out  WIDTH*UNIT_SIZE: packed results; lane i occupies o_res[i*UNIT_SIZE +: UNIT_SIZE].

## Operation
- Each lane has one UNIT_SIZE-bit result register R[i]. o_res is R driven directly, with no combinational path from the inputs.
- Operands are two's-complement signed.
- On a rising edge with i_run=1, every lane updates in parallel:
  - ADD: R = a + b.
  - SUB: R = a − b.
  - MAC: R = R + a*b. The full product is formed and the low UNIT_SIZE bits of the sum are kept.
  - MUL: R = low UNIT_SIZE bits of a*b.
- Results wrap modulo 2^UNIT_SIZE, unless the saturation option is compiled in (see Configuration).
- With i_run=0, R holds its value, regardless of i_op or operand changes.
- The MAC accumulator is R itself. The only way to clear it is reset, or issuing ADD/SUB/MUL, which overwrites R.
- i_op is sampled on the same edge as i_run. Changing i_op while i_run=0 has no effect.

## Timing
- Reset (i_rstn=0, asynchronous): all R = 0, so o_res = 0, and o_valid = 0. These hold while reset is asserted.
- Release of reset is synchronous to i_clk. The first update occurs on the first rising edge after deassertion with i_run=1.
- Latency is 1 cycle. Operands and op present before edge k appear on o_res after edge k.
- o_valid is a registered copy of i_run: it is 1 in the cycle following each edge where i_run=1, otherwise 0.
- Continuous i_run=1 gives one operation per cycle, with full throughput. In MAC mode that means one accumulation per cycle.
- There is no backpressure; results must be consumed while o_valid=1, or read later, since R holds.
- If reset is asserted mid-sequence, in-flight accumulations are lost and R returns to 0 immediately.

## Configuration
- SIMD_ARRAY_SAT_EN defined:
  - ADD, SUB and MAC saturate to the signed range [−2^(UNIT_SIZE−1), 2^(UNIT_SIZE−1)−1].
  - MAC saturates on the final sum.
  - MUL saturates the full product to the same range.
- SIMD_ARRAY_SAT_EN undefined (default): all operations wrap modulo 2^UNIT_SIZE.
- The interface is identical in both builds.

## Test plan
- Reset, then ADD with a[i]=b[i]=i and i_run=1 for one edge -> o_res lanes = 0, 2, 4, 6, 8; o_valid=1 for one cycle.
- SUB with a[i]=3(i+2), b[i]=4i -> lanes 6, 5, 4, 3, 2 (hex 6, 5, 4, 3, 2).
- Reset, then MAC one edge with a = {4, 6, 8, 10, 12}, b = {2, 3, 4, 5, 14} -> lanes 8, 18, 32, 50, 168. Then i_run=0 for two cycles -> o_res unchanged, o_valid=0.
- Continue MAC with a = {2, 4, 6, 8, 91}, b = {3, 4, 5, 6, −1} -> lanes 14, 34, 62, 98, 77. This checks the signed operand.
- ADD with a = 0x7FFFFFFF, b = 1 in lane 0 -> 0x80000000 without the macro; 0x7FFFFFFF with SIMD_ARRAY_SAT_EN.
- Assert i_rstn mid-stream, between edges -> o_res=0 and o_valid=0 immediately. The next MAC of 2*3 -> lane 0 = 6.

Source files
------------

// File: rtl/simd_array.sv
// rtl/simd_array.sv - lane-parallel ADD/SUB/MAC/MUL array with registered packed results
// Optional SIMD_ARRAY_SAT_EN macro selects signed saturation instead of modulo wrap.
module simd_array #(
  parameter int UNIT_SIZE = 32,
  parameter int WIDTH     = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [1:0]                 i_op,
  input  logic [UNIT_SIZE-1:0]       i_a [WIDTH],
  input  logic [UNIT_SIZE-1:0]       i_b [WIDTH],
  input  logic                       i_run,
  output logic                       o_valid,
  output logic [WIDTH*UNIT_SIZE-1:0] o_res
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MAC = 2'd2;

  logic [UNIT_SIZE-1:0] res_q [WIDTH];
  logic [UNIT_SIZE-1:0] res_d [WIDTH];
  logic                 valid_q;
  logic                 valid_d;

  always_comb begin
    valid_d = i_run;
  end

`ifdef SIMD_ARRAY_SAT_EN
  // Wide enough for R + full product without loss, so the clamp sees the true sum.
  localparam int XW = 2 * UNIT_SIZE + 1;
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-UNIT_SIZE+1){1'b0}}, {(UNIT_SIZE-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-UNIT_SIZE+1){1'b1}}, {(UNIT_SIZE-1){1'b0}}};

  logic signed [XW-1:0] a_x  [WIDTH];
  logic signed [XW-1:0] b_x  [WIDTH];
  logic signed [XW-1:0] r_x  [WIDTH];
  logic signed [XW-1:0] wide [WIDTH];

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      a_x[i] = {{(XW-UNIT_SIZE){i_a[i][UNIT_SIZE-1]}}, i_a[i]};
      b_x[i] = {{(XW-UNIT_SIZE){i_b[i][UNIT_SIZE-1]}}, i_b[i]};
      r_x[i] = {{(XW-UNIT_SIZE){res_q[i][UNIT_SIZE-1]}}, res_q[i]};
      case (i_op)
        OP_ADD:  wide[i] = a_x[i] + b_x[i];
        OP_SUB:  wide[i] = a_x[i] - b_x[i];
        OP_MAC:  wide[i] = r_x[i] + a_x[i] * b_x[i];
        default: wide[i] = a_x[i] * b_x[i];
      endcase
      // Clamp value is the signed extreme on the side given by the true sign.
      if (!i_run) begin
        res_d[i] = res_q[i];
      end else if ((wide[i] > SAT_MAX) || (wide[i] < SAT_MIN)) begin
        res_d[i] = {wide[i][XW-1], {(UNIT_SIZE-1){~wide[i][XW-1]}}};
      end else begin
        res_d[i] = wide[i][UNIT_SIZE-1:0];
      end
    end
  end
`else
  // Low UNIT_SIZE bits of sums and products are sign-agnostic, so narrow arithmetic suffices.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!i_run) begin
        res_d[i] = res_q[i];
      end else begin
        case (i_op)
          OP_ADD:  res_d[i] = i_a[i] + i_b[i];
          OP_SUB:  res_d[i] = i_a[i] - i_b[i];
          OP_MAC:  res_d[i] = res_q[i] + i_a[i] * i_b[i];
          default: res_d[i] = i_a[i] * i_b[i];
        endcase
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < WIDTH; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_pack
    assign o_res[g*UNIT_SIZE +: UNIT_SIZE] = res_q[g];
  end

  assign o_valid = valid_q;

endmodule

// File: tb/tb_simd_array.sv
// tb/tb_simd_array.sv - self-checking bench for simd_array (directed vectors plus randomized model comparison)
// Honours SIMD_ARRAY_SAT_EN the same way as the design.
module tb_simd_array;

  localparam int U = 32;
  localparam int W = 5;

  logic           i_clk = 1'b0;
  logic           i_rstn;
  logic [1:0]     i_op;
  logic [U-1:0]   i_a [W];
  logic [U-1:0]   i_b [W];
  logic           i_run;
  logic           o_valid;
  logic [W*U-1:0] o_res;

  int errors = 0;
  int checks = 0;
  logic [U-1:0] mdl [W];

  always #5 i_clk = ~i_clk;

  simd_array #(.UNIT_SIZE(U), .WIDTH(W)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_op   (i_op),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_run  (i_run),
    .o_valid(o_valid),
    .o_res  (o_res)
  );

  // Reference: exact signed integer math, then wrap or clamp to U bits.
  function automatic logic [U-1:0] lane_ref(input logic [1:0] op, input logic [U-1:0] r,
                                            input logic [U-1:0] a, input logic [U-1:0] b);
    longint sa, sb, sr, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = longint'($signed(r));
    case (op)
      2'd0:    full = sa + sb;
      2'd1:    full = sa - sb;
      2'd2:    full = sr + sa * sb;
      default: full = sa * sb;
    endcase
`ifdef SIMD_ARRAY_SAT_EN
    if (full > 64'sd2147483647) full = 64'sd2147483647;
    else if (full < -64'sd2147483648) full = -64'sd2147483648;
`endif
    return full[U-1:0];
  endfunction

  function automatic logic [W*U-1:0] mdl_packed();
    logic [W*U-1:0] p;
    for (int l = 0; l < W; l++) p[l*U +: U] = mdl[l];
    return p;
  endfunction

  task automatic cycle(input logic run, input logic [1:0] op);
    i_run = run;
    i_op  = op;
    if (run) for (int l = 0; l < W; l++) mdl[l] = lane_ref(op, mdl[l], i_a[l], i_b[l]);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_run  = 1'b0;
    i_rstn = 1'b0;
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    for (int l = 0; l < W; l++) mdl[l] = '0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0;
    i_run  = 1'b1;
    i_op   = 2'd0;
    for (int l = 0; l < W; l++) begin i_a[l] = 32'd7; i_b[l] = 32'd9; mdl[l] = '0; end
    #12;
    checks++;
    if (o_res !== '0) begin errors++; $display("FAIL reset_res got=%h exp=0", o_res); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    i_run = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  task automatic test_add_sub();
    for (int l = 0; l < W; l++) begin i_a[l] = U'(l); i_b[l] = U'(l); end
    cycle(1'b1, 2'd0);
    for (int l = 0; l < W; l++) begin
      checks++;
      if (o_res[l*U +: U] !== U'(2 * l)) begin
        errors++; $display("FAIL add_lane%0d got=%0d exp=%0d", l, o_res[l*U +: U], 2 * l);
      end
    end
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", o_valid); end
    cycle(1'b0, 2'd1);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop got=%b exp=0", o_valid); end
    for (int l = 0; l < W; l++) begin i_a[l] = U'(3 * (l + 2)); i_b[l] = U'(4 * l); end
    cycle(1'b1, 2'd1);
    for (int l = 0; l < W; l++) begin
      checks++;
      if (o_res[l*U +: U] !== U'(6 - l)) begin
        errors++; $display("FAIL sub_lane%0d got=%0d exp=%0d", l, o_res[l*U +: U], 6 - l);
      end
    end
  endtask

  task automatic test_mac();
    int a1 [W] = '{4, 6, 8, 10, 12};
    int b1 [W] = '{2, 3, 4, 5, 14};
    int e1 [W] = '{8, 18, 32, 50, 168};
    int a2 [W] = '{2, 4, 6, 8, 91};
    int b2 [W] = '{3, 4, 5, 6, -1};
    int e2 [W] = '{14, 34, 62, 98, 77};
    do_reset();
    for (int l = 0; l < W; l++) begin i_a[l] = U'(a1[l]); i_b[l] = U'(b1[l]); end
    cycle(1'b1, 2'd2);
    for (int l = 0; l < W; l++) begin
      checks++;
      if (o_res[l*U +: U] !== U'(e1[l])) begin
        errors++; $display("FAIL mac1_lane%0d got=%0d exp=%0d", l, o_res[l*U +: U], e1[l]);
      end
    end
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < W; l++) begin i_a[l] = $urandom; i_b[l] = $urandom; end
      cycle(1'b0, 2'(c));
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL mac_idle_valid got=%b exp=0", o_valid); end
      for (int l = 0; l < W; l++) begin
        checks++;
        if (o_res[l*U +: U] !== U'(e1[l])) begin
          errors++; $display("FAIL mac_hold_lane%0d got=%0d exp=%0d", l, o_res[l*U +: U], e1[l]);
        end
      end
    end
    for (int l = 0; l < W; l++) begin i_a[l] = U'(a2[l]); i_b[l] = U'(b2[l]); end
    cycle(1'b1, 2'd2);
    for (int l = 0; l < W; l++) begin
      checks++;
      if (o_res[l*U +: U] !== U'(e2[l])) begin
        errors++; $display("FAIL mac2_lane%0d got=%0d exp=%0d", l, o_res[l*U +: U], e2[l]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [U-1:0] exp0;
`ifdef SIMD_ARRAY_SAT_EN
    exp0 = 32'h7FFF_FFFF;
`else
    exp0 = 32'h8000_0000;
`endif
    for (int l = 0; l < W; l++) begin i_a[l] = '0; i_b[l] = '0; end
    i_a[0] = 32'h7FFF_FFFF;
    i_b[0] = 32'd1;
    cycle(1'b1, 2'd0);
    checks++;
    if (o_res[U-1:0] !== exp0) begin
      errors++; $display("FAIL overflow_lane0 got=%h exp=%h", o_res[U-1:0], exp0);
    end
  endtask

  task automatic test_mid_reset();
    for (int l = 0; l < W; l++) begin i_a[l] = U'(l + 5); i_b[l] = U'(l + 1); end
    cycle(1'b1, 2'd2);
    #2;
    i_rstn = 1'b0;
    #1;
    checks++;
    if (o_res !== '0) begin errors++; $display("FAIL midreset_res got=%h exp=0", o_res); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", o_valid); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int l = 0; l < W; l++) begin mdl[l] = '0; i_a[l] = '0; i_b[l] = '0; end
    i_a[0] = 32'd2;
    i_b[0] = 32'd3;
    cycle(1'b1, 2'd2);
    checks++;
    if (o_res !== {{((W-1)*U){1'b0}}, 32'd6}) begin
      errors++; $display("FAIL midreset_mac got=%h exp=lane0 6", o_res);
    end
  endtask

  task automatic test_random();
    logic run;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < W; l++) begin
        if ($urandom_range(0, 2) == 0) begin
          i_a[l] = $urandom; i_b[l] = $urandom;
        end else begin
          i_a[l] = U'($signed($urandom_range(0, 200)) - 100);
          i_b[l] = U'($signed($urandom_range(0, 200)) - 100);
        end
      end
      run = ($urandom_range(0, 3) != 0);
      cycle(run, 2'($urandom_range(0, 3)));
      checks++;
      if (o_valid !== run) begin errors++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, o_valid, run); end
      checks++;
      if (o_res !== mdl_packed()) begin
        errors++; $display("FAIL rand_res c=%0d got=%h exp=%h", c, o_res, mdl_packed());
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mac();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
